alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one iterative ALU between the PC-increment requester (0) and the execute requester (1).
// Latency: 3 + B cycles from IDLE sampling a request to its done pulse (B = RUN cycles with alu_busy high).
// Backpressure: requesters hold req and operands until done; a waiting requester simply stays pending in IDLE.
// Optional macro ALU_ARBITER_ROUND_ROBIN_EN: alternate grants on simultaneous requests (default: req0 wins).
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] w1_0,
  input  logic [31:0] w1_1,
  input  logic [31:0] w2_0,
  input  logic [31:0] w2_1,
  input  logic [31:0] preinit_0,
  input  logic [31:0] preinit_1,
  input  logic [2:0]  nibbles_0,
  input  logic [2:0]  nibbles_1,
  input  logic        signed_0,
  input  logic        signed_1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] result,
  output logic [1:0]  grant,
  output logic        alu_perm_to_count,
  output logic [31:0] alu_w1,
  output logic [31:0] alu_w2,
  output logic [31:0] alu_preinit_result,
  output logic [2:0]  alu_loop_nibbles_number,
  output logic        alu_word2_is_negative,
  input  logic        alu_busy,
  input  logic [31:0] alu_result
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_w1;
  logic [31:0] r_w2;
  logic [31:0] r_pre;
  logic [2:0]  r_nib;
  logic        r_sgn;
  logic [1:0]  r_grant;
  logic [31:0] r_result;
  logic        w_sel1;
  logic        w_any_req;
  logic        w_active;

  assign w_any_req = req0 | req1;

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
  // 1 means requester 1 is favoured on the next tie
  logic r_rr_ptr;

  // Favour whoever was not served last; updated once the operation completes
  always_ff @(posedge clk) begin
    if (rst)
      r_rr_ptr <= 1'b0;
    else if (r_state == S_RESP)
      r_rr_ptr <= r_grant[0];
  end

  assign w_sel1 = req1 & (~req0 | r_rr_ptr);
`else
  assign w_sel1 = req1 & ~req0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state logic; RUN always lasts at least one cycle because LAUNCH never skips it
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_RUN;
      S_RUN:    if (!alu_busy) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Operand latch, grant and result capture; operands are only sampled in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w1     <= '0;
      r_w2     <= '0;
      r_pre    <= '0;
      r_nib    <= '0;
      r_sgn    <= 1'b0;
      r_grant  <= 2'b00;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_w1    <= w_sel1 ? w1_1      : w1_0;
            r_w2    <= w_sel1 ? w2_1      : w2_0;
            r_pre   <= w_sel1 ? preinit_1 : preinit_0;
            r_nib   <= w_sel1 ? nibbles_1 : nibbles_0;
            r_sgn   <= w_sel1 ? signed_1  : signed_0;
            r_grant <= w_sel1 ? 2'b10     : 2'b01;
          end
        end
        S_RUN:    if (!alu_busy) r_result <= alu_result;
        S_RESP:   r_grant <= 2'b00;
        default:  ;
      endcase
    end
  end

  // ALU-facing outputs only carry the latched operation while it is in flight
  always_comb begin
    w_active                = (r_state == S_LAUNCH) || (r_state == S_RUN);
    alu_perm_to_count       = (r_state == S_LAUNCH);
    alu_w1                  = w_active ? r_w1  : 32'd0;
    alu_w2                  = w_active ? r_w2  : 32'd0;
    alu_preinit_result      = w_active ? r_pre : 32'd0;
    alu_loop_nibbles_number = w_active ? r_nib : 3'd0;
    // Sign bit is the top bit of the most significant processed nibble
    alu_word2_is_negative   = w_active & r_sgn & r_w2[{r_nib, 2'b11}];
    done0                   = (r_state == S_RESP) & r_grant[0];
    done1                   = (r_state == S_RESP) & r_grant[1];
    grant                   = r_grant;
    result                  = r_result;
  end

endmodule
